fetch_align: RTL
================

// Module: fetch_align
// PURPOSE
//   Instruction fetch and alignment stage directly upstream of the decode stage. Fetches
//   word-aligned 32-bit words from instruction memory into a halfword queue. Presents one
//   instruction per handshake to decode on a 32-bit bus: RVC (16-bit) instructions are
//   zero-extended, and 32-bit instructions that straddle a word boundary are reassembled.
//   Flushes and refetches on a control-flow redirect.
// PARAMETERS
//   RESET_PC  32'h00000000  PC after reset; bit 0 must be 0, bit 1 may be 1
//   QDEPTH    4             halfword queue depth; even, >= 4
// PORTS
//   I_clk          in   1   clock, all state updates on rising edge
//   I_rst          in   1   synchronous, active-high reset
//   O_imem_req     out  1   memory request (registered)
//   O_imem_addr    out  32  word address, bits[1:0]=00, stable while O_imem_req=1
//   I_imem_ack     in   1   transaction complete when O_imem_req && I_imem_ack
//   I_imem_data    in   32  fetched word, valid in the ack cycle; halfword 0 = bits[15:0]
//   O_valid        out  1   O_data/O_pc hold a complete instruction
//   I_ready        in   1   decode consumes the instruction when O_valid && I_ready
//   O_data         out  32  instruction to decode (16-bit: {16'h0000, hw})
//   O_pc           out  32  address of the instruction on O_data
//   I_redirect     in   1   flush and restart fetch at I_target
//   I_target       in   32  redirect PC; bit 0 ignored (treated as 0)
// BEHAVIOUR
//   Reset: O_imem_req=0, O_valid=0, O_data=0, queue empty, fetch state IDLE,
//     fetch addr=RESET_PC&~3, O_pc=RESET_PC, skip=RESET_PC[1].
//   Fetch FSM: IDLE -> WAIT when queue free slots minus in-flight >= 2; sets O_imem_req=1.
//     WAIT -> IDLE on ack: push 2 halfwords, or only the upper one if skip=1 (skip then
//     clears); fetch addr += 4.
//     WAIT -> FLUSH on I_redirect without ack: req stays high until ack, data discarded.
//     FLUSH -> IDLE on ack.
//     Acks seen while req=0 are ignored.
//   Instruction length: hw0[1:0]==2'b11 -> 32-bit, needs 2 queued halfwords,
//     O_data={hw1,hw0}; otherwise 16-bit, needs 1, O_data={16'h0,hw0}.
//   O_valid=1 iff the queue holds enough halfwords for the head instruction.
//     O_data/O_pc derive combinationally from the queue head; no latency beyond the queue.
//   Consume (O_valid && I_ready && !I_redirect): pop 1 or 2 halfwords; O_pc += 2 or 4,
//     matching decode's pcincr. Push and pop in the same cycle are both honoured.
//   FENCE substitution stays in decode; this block passes words unchanged.
//   Redirect, registered: next cycle queue empty, O_valid=0, O_pc=target,
//     fetch addr=target&~3, skip=target[1].
//     Redirect wins over a same-cycle consume and a same-cycle ack (data dropped).
//     If redirect coincides with an ack, FSM goes to IDLE, not FLUSH.
//   Full queue: no request issued. Empty queue: O_valid=0.
//     Upper halfword of a 32-bit instruction not yet arrived: O_valid=0 and the lower
//     halfword is retained.
//   Fetch addr wraps 32'hFFFFFFFC -> 0 (mod 2^32); O_pc likewise.
//   Reset mid-transaction: immediate return to reset state; a late ack is ignored
//     (req=0).
// STRUCTURE
//   general_definitions.vh: FETCH_IDLE/WAIT/FLUSH encodings (2 bit),
//     `INSTR32_LSB 2'b11, `NOP_WORD (ADDI x0,x0,0).
//   One sub-module: hw_queue (16-bit wide, QDEPTH entries, push 0/1/2, pop 0/1/2,
//     count, peek head and head+1, sync clear).
// TESTING
//   1 Reset, RESET_PC=0, mem word0=32'h00500093, 1-cycle ack -> O_data=32'h00500093,
//     O_pc=0, then O_pc=4.
//   2 Word0=32'h45014505 (two C.LI), I_ready=1 -> O_data=32'h00004505 @pc 0, then
//     32'h00004501 @pc 2.
//   3 Word0={32-bit lo,16'h4505}, word1={..,hi} -> 16-bit @0, then reassembled 32-bit
//     @2, next @6.
//   4 I_redirect target=32'h00000102 during WAIT, ack 3 cycles later -> stale data
//     dropped; next req addr 32'h100, first O_pc=32'h102 from upper halfword.
//   5 I_ready=0 for 10 cycles -> queue fills, O_imem_req stays 0 when full, O_data
//     stable; release drains in order.
//   6 Redirect + ack + consume same cycle; I_rst asserted mid-WAIT -> redirect wins,
//     no push/pop; after reset O_valid=0, O_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_align_pkg.sv
// fetch_align_pkg: fetch FSM states and instruction-length helper shared by the fetch stage.
package fetch_align_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [1:0] INSTR32_LSB = 2'b11;

    function automatic logic is_instr32(input logic [15:0] hw);
        return hw[1:0] == INSTR32_LSB;
    endfunction

endpackage

// File: rtl/fetch_align_hw_queue.sv
// fetch_align_hw_queue: halfword FIFO, push 0/1/2 and pop 0/1/2 per cycle, head and head+1 peek.
module fetch_align_hw_queue #(
    parameter int QDEPTH = 4,
    parameter int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          I_clk,
    input  logic          I_rst,
    input  logic          I_clear,
    input  logic [1:0]    I_push_n,
    input  logic [31:0]   I_push_data,
    input  logic [1:0]    I_pop_n,
    output logic [CW-1:0] O_count,
    output logic [15:0]   O_head0,
    output logic [15:0]   O_head1
);

    logic [15:0]   r_mem  [QDEPTH];
    logic [15:0]   w_next [QDEPTH];
    logic [CW-1:0] r_count;
    int            w_keep;

    assign w_keep  = int'(r_count) - int'(I_pop_n);
    assign O_count = r_count;
    assign O_head0 = r_mem[0];
    assign O_head1 = r_mem[1];

    // Entries stay packed at index 0: survivors shift down, pushes land right behind them.
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            w_next[i] = r_mem[i];
            if (i < w_keep)
                w_next[i] = I_pop_n == 2'd2 ? r_mem[(i + 2) % QDEPTH] :
                            I_pop_n == 2'd1 ? r_mem[(i + 1) % QDEPTH] : r_mem[i];
            else if (i == w_keep && I_push_n != 2'd0)
                w_next[i] = I_push_data[15:0];
            else if (i == w_keep + 1 && I_push_n == 2'd2)
                w_next[i] = I_push_data[31:16];
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
        end else if (I_clear) begin
            r_count <= '0;
        end else begin
            r_count <= CW'(w_keep + int'(I_push_n));
            for (int i = 0; i < QDEPTH; i++) r_mem[i] <= w_next[i];
        end
    end

endmodule

// File: rtl/fetch_align.sv
// fetch_align: fetches memory words into a halfword queue and hands decode one aligned
// instruction per handshake, reassembling 32-bit instructions that straddle words.
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        I_clk,
    input  logic        I_rst,
    output logic        O_imem_req,
    output logic [31:0] O_imem_addr,
    input  logic        I_imem_ack,
    input  logic [31:0] I_imem_data,
    output logic        O_valid,
    input  logic        I_ready,
    output logic [31:0] O_data,
    output logic [31:0] O_pc,
    input  logic        I_redirect,
    input  logic [31:0] I_target
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t  r_state;
    logic          r_req;
    logic          r_skip;
    logic [31:0]   r_addr;
    logic [31:0]   r_req_addr;
    logic [31:0]   r_pc;
    logic [CW-1:0] w_count;
    logic [15:0]   w_hw0;
    logic [15:0]   w_hw1;
    logic          w_is32;
    logic          w_ack;
    logic          w_take;
    logic          w_push;
    logic          w_room;
    logic [1:0]    w_pop_n;
    logic [1:0]    w_push_n;
    logic [31:0]   w_push_data;

    assign w_is32      = is_instr32(w_hw0);
    assign O_valid     = w_count >= (w_is32 ? CW'(2) : CW'(1));
    assign O_data      = w_is32 ? {w_hw1, w_hw0} : {16'h0000, w_hw0};
    assign O_pc        = r_pc;
    assign O_imem_req  = r_req;
    assign O_imem_addr = r_req_addr;
    assign w_ack       = r_req && I_imem_ack;
    assign w_take      = O_valid && I_ready && !I_redirect;
    assign w_pop_n     = w_take ? (w_is32 ? 2'd2 : 2'd1) : 2'd0;
    assign w_push      = w_ack && r_state == FETCH_WAIT && !I_redirect;
    assign w_push_n    = w_push ? (r_skip ? 2'd1 : 2'd2) : 2'd0;
    assign w_push_data = r_skip ? {16'h0000, I_imem_data[31:16]} : I_imem_data;
    // Only issue from IDLE, so nothing is in flight and two free slots cover the reply.
    assign w_room      = w_count <= CW'(QDEPTH - 2);

    fetch_align_hw_queue #(.QDEPTH(QDEPTH), .CW(CW)) u_queue (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_clear    (I_redirect),
        .I_push_n   (w_push_n),
        .I_push_data(w_push_data),
        .I_pop_n    (w_pop_n),
        .O_count    (w_count),
        .O_head0    (w_hw0),
        .O_head1    (w_hw1)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state    <= FETCH_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC & ~32'h3;
            r_req_addr <= RESET_PC & ~32'h3;
            r_pc       <= RESET_PC;
            r_skip     <= RESET_PC[1];
        end else begin
            if (w_take) r_pc <= r_pc + (w_is32 ? 32'd4 : 32'd2);
            if (w_push) begin
                r_addr <= r_addr + 32'd4;
                r_skip <= 1'b0;
            end
            if (I_redirect) begin
                r_pc   <= I_target & ~32'h1;
                r_addr <= I_target & ~32'h3;
                r_skip <= I_target[1];
            end
            case (r_state)
                FETCH_IDLE:
                    if (!I_redirect && w_room) begin
                        r_state    <= FETCH_WAIT;
                        r_req      <= 1'b1;
                        r_req_addr <= r_addr;
                    end
                FETCH_WAIT:
                    if (w_ack) begin
                        r_state <= FETCH_IDLE;
                        r_req   <= 1'b0;
                    end else if (I_redirect) begin
                        r_state <= FETCH_FLUSH;
                    end
                FETCH_FLUSH:
                    if (w_ack) begin
                        r_state <= FETCH_IDLE;
                        r_req   <= 1'b0;
                    end
                default: begin
                    r_state <= FETCH_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
